copro_op_sequencer: RTL and testbench
=====================================

// Module: copro_op_sequencer
// PURPOSE
//  Sequences floating-point ops (add/sub/mul/div) from the LM32 custom-instruction side onto one
//  shared multi-cycle float unit (start/done handshake). Latches operands, issues, waits, returns
//  result; bypasses divide-by-zero; aborts on unit timeout. Sits between CPU copro port and FPU.
// PARAMETERS
//  TIMEOUT   64   max cycles from fu_start to fu_done before abort (>=2)
//  CNT_W     $clog2(TIMEOUT+1)  derived: timeout counter width
// PORTS
//  clk            in   1        clock, all state on rising edge
//  reset_n        in   1        asynchronous active-low reset
//  cpu_valid      in   1        request present; held high until cpu_complete seen
//  cpu_op         in   2        op_t: 0 ADD, 1 SUB, 2 MUL, 3 DIV
//  cpu_a          in   FW       operand 1 (float_pack::float, FW=$bits(float))
//  cpu_b          in   FW       operand 2
//  cpu_complete   out  1        one-cycle pulse: cpu_result valid
//  cpu_result     out  FW       result, held until next completion
//  fu_start       out  1        one-cycle pulse: launch float unit
//  fu_op          out  2        op to unit, stable from fu_start until fu_done/abort
//  fu_a, fu_b     out  FW       operands to unit, stable likewise
//  fu_done        in   1        unit finished (one-cycle pulse)
//  fu_result      in   FW       unit result, valid with fu_done
//  busy           out  1        high in any state but IDLE
//  err_dz         out  1        sticky: divide by zero occurred
//  err_to         out  1        sticky: unit timeout occurred
//  err_clr        in   1        clears both sticky flags (same-cycle set wins)
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0 (cpu_result, fu_a/b/op, flags, counter 0).
//  FSM IDLE -> LATCH -> (BYPASS | ISSUE) -> WAIT -> DONE -> IDLE.
//   IDLE:   cpu_valid=1 -> LATCH; register op/a/b into fu_op/fu_a/fu_b.
//   LATCH:  DIV with fu_b.exp==0 && fu_b.mant==0 -> BYPASS; else -> ISSUE.
//   BYPASS: result = {a.s^b.s, exp all-ones, mant 0} (infinity); set err_dz; -> DONE. No fu_start.
//   ISSUE:  fu_start=1 for exactly this cycle; counter<=0; -> WAIT.
//   WAIT:   fu_done -> latch fu_result -> DONE. Else counter++; counter==TIMEOUT-1 and no fu_done
//           -> result all-zero, set err_to, -> DONE. fu_done on that same cycle wins (normal path).
//   DONE:   cpu_complete=1 for one cycle, cpu_result updated same cycle; -> IDLE.
//  Latency (normal): cpu_valid accepted in IDLE at cycle 0; fu_start at cycle 2; complete 1 cycle
//   after fu_done cycle. Bypass: complete at cycle 3.
//  cpu_valid still high in IDLE right after DONE is a NEW request (CPU must drop it after
//   cpu_complete; treat as back-to-back, no dead cycle required beyond IDLE).
//  fu_done outside WAIT ignored (late done after timeout dropped, no state change).
//  cpu_op/a/b changes after LATCH ignored; only latched copy used.
//  err_clr and set in same cycle: flag ends 1.
//  reset_n low mid-op: immediate return to IDLE, no complete pulse; unit left to finish, its
//   fu_done ignored.
//  Widths: all float ports are float_pack::float; no arithmetic here beyond zero test and counter.
// STRUCTURE
//  float_pack: add op_t enum (OP_ADD..OP_DIV), seq_state_t enum, function is_zero(float),
//   function float_inf(logic s). Float type already in package.
//  Single module, no sub-module; timeout counter inline.
// TESTING
//  1 ADD a=1.5 b=2.25, fu_done 3 cyc after fu_start, fu_result=3.75 -> one fu_start, complete
//    1 cyc after done, cpu_result=3.75, flags 0.
//  2 DIV a=-2.0 b=0.0 -> no fu_start, complete at cycle 3, result -inf, err_dz=1, sticks.
//  3 MUL, unit never asserts done, TIMEOUT=8 -> complete 8 cyc after fu_start, result 0, err_to=1;
//    late fu_done 2 cyc later ignored, busy=0.
//  4 Back-to-back: SUB 5.0-1.0 then MUL 2.0*3.0 with cpu_valid held -> two fu_start pulses,
//    results 4.0 then 6.0, fu_a/fu_b stable during each WAIT.
//  5 reset_n low during WAIT -> IDLE, outputs 0, no cpu_complete; following ADD completes normally.
//  6 err_clr pulsed on cycle err_dz sets -> err_dz=1; err_clr next cycle -> err_dz=0.

Source files
------------

// File: rtl/float_pack.sv
// Shared float format plus the op and sequencer-state types used by the
// coprocessor op sequencer.
package float_pack;

    typedef struct packed {
        logic        s;
        logic [7:0]  exp;
        logic [22:0] mant;
    } float;

    localparam int FW = $bits(float);

    typedef enum logic [1:0] {
        OP_ADD = 2'd0,
        OP_SUB = 2'd1,
        OP_MUL = 2'd2,
        OP_DIV = 2'd3
    } op_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LATCH,
        ST_BYPASS,
        ST_ISSUE,
        ST_WAIT,
        ST_DONE
    } seq_state_t;

    // The sign is ignored, so -0.0 also counts as zero.
    function automatic logic is_zero(input float f);
        return (f.exp == 8'd0) && (f.mant == 23'd0);
    endfunction

    function automatic float float_inf(input logic s);
        float f;
        f.s    = s;
        f.exp  = '1;
        f.mant = '0;
        return f;
    endfunction

endpackage

// File: rtl/copro_op_sequencer.sv
// Accepts one float op from the CPU coprocessor port, runs it on the shared
// multi-cycle float unit and returns the result, with divide-by-zero bypass
// and a timeout abort.
module copro_op_sequencer
    import float_pack::*;
#(
    parameter int TIMEOUT = 64
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          cpu_valid,
    input  logic [1:0]    cpu_op,
    input  logic [FW-1:0] cpu_a,
    input  logic [FW-1:0] cpu_b,
    output logic          cpu_complete,
    output logic [FW-1:0] cpu_result,
    output logic          fu_start,
    output logic [1:0]    fu_op,
    output logic [FW-1:0] fu_a,
    output logic [FW-1:0] fu_b,
    input  logic          fu_done,
    input  logic [FW-1:0] fu_result,
    output logic          busy,
    output logic          err_dz,
    output logic          err_to,
    input  logic          err_clr
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    // Abort once the incremented count would reach TIMEOUT-1, which puts the
    // completion exactly TIMEOUT cycles after fu_start.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 2);

    seq_state_t       state_q;
    logic [CNT_W-1:0] cnt_q;
    op_t              fu_op_q;
    float             fu_a_q;
    float             fu_b_q;
    float             result_q;
    logic             fu_start_q;
    logic             complete_q;
    logic             busy_q;
    logic             err_dz_q;
    logic             err_to_q;
    logic             set_dz;
    logic             set_to;

    assign set_dz = (state_q == ST_BYPASS);
    assign set_to = (state_q == ST_WAIT) && !fu_done && (cnt_q == CNT_LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            fu_op_q    <= OP_ADD;
            fu_a_q     <= '0;
            fu_b_q     <= '0;
            result_q   <= '0;
            fu_start_q <= 1'b0;
            complete_q <= 1'b0;
            busy_q     <= 1'b0;
            err_dz_q   <= 1'b0;
            err_to_q   <= 1'b0;
        end else begin
            fu_start_q <= 1'b0;
            complete_q <= 1'b0;
            err_dz_q   <= set_dz | (err_dz_q & ~err_clr);
            err_to_q   <= set_to | (err_to_q & ~err_clr);
            case (state_q)
                ST_IDLE: begin
                    if (cpu_valid) begin
                        fu_op_q <= op_t'(cpu_op);
                        fu_a_q  <= cpu_a;
                        fu_b_q  <= cpu_b;
                        busy_q  <= 1'b1;
                        state_q <= ST_LATCH;
                    end
                end
                ST_LATCH: begin
                    if (fu_op_q == OP_DIV && is_zero(fu_b_q)) begin
                        state_q <= ST_BYPASS;
                    end else begin
                        fu_start_q <= 1'b1;
                        state_q    <= ST_ISSUE;
                    end
                end
                ST_BYPASS: begin
                    result_q   <= float_inf(fu_a_q.s ^ fu_b_q.s);
                    complete_q <= 1'b1;
                    state_q    <= ST_DONE;
                end
                ST_ISSUE: begin
                    cnt_q   <= '0;
                    state_q <= ST_WAIT;
                end
                // A done arriving on the last allowed cycle still wins over the abort.
                ST_WAIT: begin
                    if (fu_done) begin
                        result_q   <= fu_result;
                        complete_q <= 1'b1;
                        state_q    <= ST_DONE;
                    end else if (cnt_q == CNT_LAST) begin
                        result_q   <= '0;
                        complete_q <= 1'b1;
                        state_q    <= ST_DONE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign cpu_complete = complete_q;
    assign cpu_result   = result_q;
    assign fu_start     = fu_start_q;
    assign fu_op        = fu_op_q;
    assign fu_a         = fu_a_q;
    assign fu_b         = fu_b_q;
    assign busy         = busy_q;
    assign err_dz       = err_dz_q;
    assign err_to       = err_to_q;

endmodule

// File: tb/tb_copro_op_sequencer.sv
// Directed bench for copro_op_sequencer: a timestamp-level transaction model
// checked every cycle, plus hand-computed latency/result expectations.
module tb_copro_op_sequencer;
    import float_pack::*;

    localparam int TO = 8;
    localparam logic [31:0] F_1_0  = 32'h3F800000;
    localparam logic [31:0] F_1_5  = 32'h3FC00000;
    localparam logic [31:0] F_2_0  = 32'h40000000;
    localparam logic [31:0] F_2_25 = 32'h40100000;
    localparam logic [31:0] F_3_0  = 32'h40400000;
    localparam logic [31:0] F_3_75 = 32'h40700000;
    localparam logic [31:0] F_4_0  = 32'h40800000;
    localparam logic [31:0] F_5_0  = 32'h40A00000;
    localparam logic [31:0] F_6_0  = 32'h40C00000;
    localparam logic [31:0] F_M2_0 = 32'hC0000000;
    localparam logic [31:0] F_MINF = 32'hFF800000;
    localparam logic [31:0] F_M0   = 32'h80000000;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          cpu_valid = 1'b0;
    logic [1:0]    cpu_op = 2'd0;
    logic [FW-1:0] cpu_a = '0;
    logic [FW-1:0] cpu_b = '0;
    logic          cpu_complete;
    logic [FW-1:0] cpu_result;
    logic          fu_start;
    logic [1:0]    fu_op;
    logic [FW-1:0] fu_a;
    logic [FW-1:0] fu_b;
    logic          fu_done = 1'b0;
    logic [FW-1:0] fu_result = '0;
    logic          busy;
    logic          err_dz;
    logic          err_to;
    logic          err_clr = 1'b0;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int nstart = 0;
    int fuDelay = -1;
    logic [31:0] fuValue = '0;
    int doneAt = -1;
    int lateAt = -1;

    copro_op_sequencer #(.TIMEOUT(TO)) dut (
        .clk(clk), .reset_n(reset_n), .cpu_valid(cpu_valid), .cpu_op(cpu_op),
        .cpu_a(cpu_a), .cpu_b(cpu_b), .cpu_complete(cpu_complete), .cpu_result(cpu_result),
        .fu_start(fu_start), .fu_op(fu_op), .fu_a(fu_a), .fu_b(fu_b),
        .fu_done(fu_done), .fu_result(fu_result), .busy(busy),
        .err_dz(err_dz), .err_to(err_to), .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc <= cyc + 1;
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("[TB] FAIL %s: got %h want %h (cycle %0d)", name, act, want, cyc);
        end
    endtask

    // Fake float unit: answers fuDelay cycles after each start, plus an optional stray done.
    initial forever begin
        @(negedge clk);
        if (fu_start) begin
            nstart++;
            if (reset_n && fuDelay >= 0) doneAt = cyc + fuDelay;
        end
    end

    initial forever begin
        @(posedge clk);
        #1;
        fu_done   = (cyc == doneAt) || (cyc == lateAt);
        fu_result = fu_done ? fuValue : 32'hDEADBEEF;
    end

    // Transaction model: accept cycle t0, start t0+2, completion cycle tc.
    bit          mActive = 0;
    bit          mBypass = 0;
    bit          mTimeout = 0;
    int          mT0 = 0;
    int          mTs = 0;
    int          mTc = -1;
    logic [31:0] mLa = '0;
    logic [31:0] mLb = '0;
    logic [1:0]  mLop = '0;
    logic [31:0] mRes = '0;
    logic [31:0] eResult = '0;
    logic [31:0] eFa = '0;
    logic [31:0] eFb = '0;
    logic [1:0]  eFop = '0;
    bit          eDz = 0;
    bit          eTo = 0;
    bit          expBusy;
    bit          expStart;
    bit          expComplete;
    bit          setDz;
    bit          setTo;

    initial forever begin
        @(negedge clk);
        if (!reset_n) begin
            checkOutput("rst_busy", busy, 0);
            checkOutput("rst_complete", cpu_complete, 0);
            checkOutput("rst_start", fu_start, 0);
            checkOutput("rst_result", cpu_result, 0);
            checkOutput("rst_fu_a", fu_a, 0);
            checkOutput("rst_fu_b", fu_b, 0);
            checkOutput("rst_fu_op", fu_op, 0);
            checkOutput("rst_err_dz", err_dz, 0);
            checkOutput("rst_err_to", err_to, 0);
            mActive = 0;
            eResult = '0; eFa = '0; eFb = '0; eFop = '0;
            eDz = 0; eTo = 0;
        end else begin
            if (mActive && cyc == mT0 + 1) begin
                eFa = mLa; eFb = mLb; eFop = mLop;
            end
            expBusy     = mActive && cyc > mT0 && (mTc < 0 || cyc <= mTc);
            expStart    = mActive && !mBypass && cyc == mT0 + 2;
            expComplete = mActive && mTc >= 0 && cyc == mTc;
            if (expComplete) eResult = mRes;
            checkOutput("busy", busy, expBusy);
            checkOutput("fu_start", fu_start, expStart);
            checkOutput("cpu_complete", cpu_complete, expComplete);
            checkOutput("cpu_result", cpu_result, eResult);
            checkOutput("fu_a", fu_a, eFa);
            checkOutput("fu_b", fu_b, eFb);
            checkOutput("fu_op", fu_op, eFop);
            checkOutput("err_dz", err_dz, eDz);
            checkOutput("err_to", err_to, eTo);

            if (mActive && !mBypass && mTc < 0 && cyc > mTs) begin
                if (fu_done) begin
                    mTc = cyc + 1; mRes = fu_result; mTimeout = 0;
                end else if (cyc == mTs + TO - 1) begin
                    mTc = mTs + TO; mRes = '0; mTimeout = 1;
                end
            end
            setDz = mActive && mBypass && (cyc + 1 == mTc);
            setTo = mActive && mTimeout && (cyc + 1 == mTc);
            eDz = setDz || (eDz && !err_clr);
            eTo = setTo || (eTo && !err_clr);

            if (cpu_valid && (!mActive || (mTc >= 0 && cyc > mTc))) begin
                mActive  = 1;
                mT0      = cyc;
                mTs      = cyc + 2;
                mLa      = cpu_a;
                mLb      = cpu_b;
                mLop     = cpu_op;
                mTimeout = 0;
                mBypass  = (cpu_op == 2'd3) && (cpu_b[30:0] == 31'd0);
                if (mBypass) begin
                    mTc  = cyc + 3;
                    mRes = {cpu_a[31] ^ cpu_b[31], 8'hFF, 23'd0};
                end else begin
                    mTc  = -1;
                end
            end
        end
    end

    // Issues one request, scrambles the CPU-side operands after latch, waits for completion.
    task automatic applyStimulus(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                 input bit keep, output int t0, output int tc);
        int n;
        @(posedge clk); #1;
        cpu_valid = 1'b1; cpu_op = op; cpu_a = a; cpu_b = b;
        t0 = cyc;
        @(posedge clk); #1;
        @(posedge clk); #1;
        cpu_a = ~a; cpu_b = ~b; cpu_op = ~op;
        tc = -1;
        n = 0;
        while (tc < 0 && n < 40) begin
            @(negedge clk);
            if (cpu_complete) tc = cyc;
            n++;
        end
        if (tc < 0) checkOutput("complete_seen", 0, 1);
        if (!keep) begin
            @(posedge clk); #1;
            cpu_valid = 1'b0;
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int t0, tc, t0b, tcb, s0;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
        checkOutput("lit_reset_busy", busy, 0);
        checkOutput("lit_reset_result", cpu_result, 0);

        // ADD with a 3-cycle unit
        fuDelay = 3; fuValue = F_3_75; s0 = nstart;
        applyStimulus(OP_ADD, F_1_5, F_2_25, 0, t0, tc);
        checkOutput("t1_latency", tc - t0, 6);
        checkOutput("t1_result", cpu_result, F_3_75);
        checkOutput("t1_starts", nstart - s0, 1);
        checkOutput("t1_err_dz", err_dz, 0);
        checkOutput("t1_err_to", err_to, 0);

        // divide by zero bypass
        fuDelay = -1; s0 = nstart;
        applyStimulus(OP_DIV, F_M2_0, 32'h0, 0, t0, tc);
        checkOutput("t2_latency", tc - t0, 3);
        checkOutput("t2_result", cpu_result, F_MINF);
        checkOutput("t2_starts", nstart - s0, 0);
        checkOutput("t2_err_dz", err_dz, 1);
        repeat (5) @(negedge clk);
        checkOutput("t2_err_dz_sticky", err_dz, 1);

        // err_clr racing the set, then clearing next cycle
        @(posedge clk); #1 err_clr = 1'b1;
        @(posedge clk); #1 err_clr = 1'b0;
        @(negedge clk);
        checkOutput("t6_pre_clear", err_dz, 0);
        @(posedge clk); #1;
        cpu_valid = 1'b1; cpu_op = OP_DIV; cpu_a = F_1_0; cpu_b = F_M0;
        t0 = cyc;
        @(posedge clk); #1;
        @(posedge clk); #1 err_clr = 1'b1;
        @(posedge clk); #1 err_clr = 1'b1;
        @(negedge clk);
        checkOutput("t6_complete_cycle", cyc - t0, 3);
        checkOutput("t6_complete", cpu_complete, 1);
        checkOutput("t6_set_wins", err_dz, 1);
        checkOutput("t6_result", cpu_result, F_MINF);
        @(posedge clk); #1;
        err_clr = 1'b0; cpu_valid = 1'b0;
        @(negedge clk);
        checkOutput("t6_cleared", err_dz, 0);

        // unit never answers: timeout, then a stray late done
        fuDelay = -1; s0 = nstart;
        applyStimulus(OP_MUL, F_2_0, F_3_0, 0, t0, tc);
        checkOutput("t3_latency", tc - t0, 2 + TO);
        checkOutput("t3_result", cpu_result, 0);
        checkOutput("t3_starts", nstart - s0, 1);
        checkOutput("t3_err_to", err_to, 1);
        fuValue = F_6_0;
        lateAt = tc + 2;
        repeat (4) begin
            @(negedge clk);
            checkOutput("t3_late_busy", busy, 0);
            checkOutput("t3_late_complete", cpu_complete, 0);
        end
        checkOutput("t3_late_result", cpu_result, 0);

        // back-to-back with cpu_valid held
        fuDelay = 2; fuValue = F_4_0; s0 = nstart;
        applyStimulus(OP_SUB, F_5_0, F_1_0, 1, t0, tc);
        checkOutput("t4a_latency", tc - t0, 5);
        checkOutput("t4a_result", cpu_result, F_4_0);
        fuValue = F_6_0;
        applyStimulus(OP_MUL, F_2_0, F_3_0, 0, t0b, tcb);
        checkOutput("t4_back_to_back", t0b - tc, 1);
        checkOutput("t4b_latency", tcb - t0b, 5);
        checkOutput("t4b_result", cpu_result, F_6_0);
        checkOutput("t4_starts", nstart - s0, 2);

        // reset in the middle of WAIT
        fuDelay = -1;
        @(posedge clk); #1;
        cpu_valid = 1'b1; cpu_op = OP_ADD; cpu_a = F_1_5; cpu_b = F_2_25;
        t0 = cyc;
        repeat (4) @(posedge clk);
        #1;
        reset_n = 1'b0; cpu_valid = 1'b0;
        @(negedge clk);
        checkOutput("t5_busy", busy, 0);
        checkOutput("t5_fu_a", fu_a, 0);
        checkOutput("t5_result", cpu_result, 0);
        checkOutput("t5_err_to", err_to, 0);
        checkOutput("t5_complete", cpu_complete, 0);
        @(posedge clk); #1 reset_n = 1'b1;
        fuDelay = 1; fuValue = F_3_75;
        applyStimulus(OP_ADD, F_1_5, F_2_25, 0, t0, tc);
        checkOutput("t5_after_latency", tc - t0, 4);
        checkOutput("t5_after_result", cpu_result, F_3_75);

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
